// File: rtl/lab8_sysid_pkg.sv
// Shared types and constants for the system-ID check master and its read engine.
package lab8_sysid_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_RD_ID  = 4'd1,
    ST_LAT_ID = 4'd2,
    ST_CHK_ID = 4'd3,
    ST_RD_TS  = 4'd4,
    ST_LAT_TS = 4'd5,
    ST_CHK_TS = 4'd6,
    ST_RETRY  = 4'd7,
    ST_DONE   = 4'd8
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_ID      = 2'b01,
    ERR_TS      = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_e;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'b11) ? v : v + 2'd1;
  endfunction

endpackage

// File: rtl/lab8_avm_read_engine.sv
// Single Avalon-MM read: holds read/address through waitrequest, delays the
// data-valid strobe by READ_LATENCY, and aborts after TIMEOUT_CYCLES stalls.
module lab8_avm_read_engine
  import lab8_sysid_pkg::*;
#(
  parameter int READ_LATENCY   = 0,
  parameter int TIMEOUT_CYCLES = 255
)(
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        req_addr,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        avm_address,
  output logic        avm_read,
  output logic        rd_accept,
  output logic        rd_done,
  output logic [31:0] rd_data,
  output logic        rd_timeout
);

  localparam int LAT_W = (READ_LATENCY > 0) ? READ_LATENCY : 1;

  logic             r_read;
  logic             r_addr;
  logic             r_timeout;
  logic [15:0]      r_wait_cnt;
  logic [LAT_W-1:0] r_lat_sr;
  logic             w_timeout_hit;

  assign rd_accept     = r_read & ~avm_waitrequest;
  assign w_timeout_hit = r_read & avm_waitrequest & (r_wait_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign rd_done       = (READ_LATENCY == 0) ? rd_accept : r_lat_sr[LAT_W-1];
  assign rd_data       = avm_readdata;
  assign rd_timeout    = r_timeout;
  assign avm_read      = r_read;
  assign avm_address   = r_addr;

  // Read strobe, stall counter and latency delay line
  always_ff @(posedge clock) begin
    if (reset) begin
      r_read     <= 1'b0;
      r_addr     <= ADDR_ID;
      r_timeout  <= 1'b0;
      r_wait_cnt <= 16'd0;
      r_lat_sr   <= '0;
    end else begin
      r_timeout <= w_timeout_hit;
      r_lat_sr  <= LAT_W'({r_lat_sr, rd_accept});
      if (req) begin
        r_read     <= 1'b1;
        r_addr     <= req_addr;
        r_wait_cnt <= 16'd0;
      end else if (rd_accept || w_timeout_hit) begin
        r_read <= 1'b0;
      end else if (r_read) begin
        r_wait_cnt <= r_wait_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/lab8_sysid_check_master.sv
// Reads the system-ID slave's ID and timestamp words and reports pass/fail.
// Optional retry-on-failure behaviour is enabled by defining SYSID_CHECK_RETRY_EN.
module lab8_sysid_check_master
  import lab8_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1520803331,
  parameter int          READ_LATENCY   = 0,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          AUTO_START     = 1,
  parameter int          MAX_RETRIES    = 3
)(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [1:0]  err_code,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [1:0]  retry_count
);

  state_e      r_state, w_next;
  err_e        r_err, w_fail_code;
  logic        r_auto, r_id_ok, r_ts_ok, r_busy, r_done, r_pass;
  logic [31:0] r_id, r_ts;
  logic        w_req, w_req_addr, w_fail, w_retry_ok, w_in_id, w_in_ts;
  logic        w_rd_accept, w_rd_done, w_rd_timeout;
  logic [31:0] w_rd_data;

  lab8_avm_read_engine #(
    .READ_LATENCY  (READ_LATENCY),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_engine (
    .clock          (clock),
    .reset          (reset),
    .req            (w_req),
    .req_addr       (w_req_addr),
    .avm_readdata   (avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .rd_accept      (w_rd_accept),
    .rd_done        (w_rd_done),
    .rd_data        (w_rd_data),
    .rd_timeout     (w_rd_timeout)
  );

  assign w_in_id = (r_state == ST_RD_ID) || (r_state == ST_LAT_ID);
  assign w_in_ts = (r_state == ST_RD_TS) || (r_state == ST_LAT_TS);

`ifdef SYSID_CHECK_RETRY_EN
  logic [15:0] r_tries;
  logic [1:0]  r_retry;

  assign w_retry_ok  = (int'(r_tries) < MAX_RETRIES);
  assign retry_count = r_retry;

  // Retry bookkeeping: cleared when a fresh check is launched
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tries <= 16'd0;
      r_retry <= 2'd0;
    end else if (w_req && ((r_state == ST_IDLE) || (r_state == ST_DONE))) begin
      r_tries <= 16'd0;
      r_retry <= 2'd0;
    end else if (w_next == ST_RETRY) begin
      r_tries <= r_tries + 16'd1;
      r_retry <= sat_inc2(r_retry);
    end
  end
`else
  assign w_retry_ok  = 1'b0;
  assign retry_count = 2'b00;
`endif

  // Next-state and read-request decode
  always_comb begin
    w_next      = r_state;
    w_req       = 1'b0;
    w_req_addr  = ADDR_ID;
    w_fail      = 1'b0;
    w_fail_code = ERR_NONE;
    case (r_state)
      ST_IDLE: begin
        if (start || r_auto) begin
          w_next = ST_RD_ID;
          w_req  = 1'b1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_RD_ID, ST_RD_TS: begin
        if (w_rd_timeout) begin
          w_fail      = 1'b1;
          w_fail_code = ERR_TIMEOUT;
        end else if (w_rd_done) begin
          w_next = (r_state == ST_RD_ID) ? ST_CHK_ID : ST_CHK_TS;
        end else if (w_rd_accept) begin
          w_next = (r_state == ST_RD_ID) ? ST_LAT_ID : ST_LAT_TS;
        end else begin
          w_next = r_state;
        end
      end
      ST_LAT_ID: w_next = w_rd_done ? ST_CHK_ID : ST_LAT_ID;
      ST_LAT_TS: w_next = w_rd_done ? ST_CHK_TS : ST_LAT_TS;
      ST_CHK_ID: begin
        if (r_id_ok) begin
          w_next     = ST_RD_TS;
          w_req      = 1'b1;
          w_req_addr = ADDR_TS;
        end else begin
          w_fail      = 1'b1;
          w_fail_code = ERR_ID;
        end
      end
      ST_CHK_TS: begin
        if (r_ts_ok) begin
          w_next = ST_DONE;
        end else begin
          w_fail      = 1'b1;
          w_fail_code = ERR_TS;
        end
      end
      ST_RETRY: begin
        w_next = ST_RD_ID;
        w_req  = 1'b1;
      end
      ST_DONE: begin
        if (start) begin
          w_next = ST_RD_ID;
          w_req  = 1'b1;
        end else begin
          w_next = ST_DONE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
    w_next = w_fail ? (w_retry_ok ? ST_RETRY : ST_DONE) : w_next;
  end

  // State, capture/compare registers and registered status outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_auto  <= (AUTO_START != 0);
      r_id_ok <= 1'b0;
      r_ts_ok <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= ERR_NONE;
      r_id    <= 32'd0;
      r_ts    <= 32'd0;
    end else begin
      r_state <= w_next;
      r_auto  <= 1'b0;
      r_busy  <= (w_next != ST_IDLE) && (w_next != ST_DONE);
      if ((r_state == ST_DONE) && start) begin
        r_done <= 1'b0;
        r_pass <= 1'b0;
        r_err  <= ERR_NONE;
        r_id   <= 32'd0;
        r_ts   <= 32'd0;
      end else if ((w_next == ST_DONE) && (r_state != ST_DONE)) begin
        r_done <= 1'b1;
        r_pass <= ~w_fail;
        r_err  <= w_fail_code;
      end
      // A retry starts from a clean capture so a skipped TS read reports 0
      if (r_state == ST_RETRY) begin
        r_id <= 32'd0;
        r_ts <= 32'd0;
      end
      if (w_rd_done && w_in_id) begin
        r_id    <= w_rd_data;
        r_id_ok <= (w_rd_data == EXPECTED_ID);
      end
      if (w_rd_done && w_in_ts) begin
        r_ts    <= w_rd_data;
        r_ts_ok <= (w_rd_data == EXPECTED_TS);
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign pass     = r_pass;
  assign err_code = r_err;
  assign id_value = r_id;
  assign ts_value = r_ts;

endmodule

// File: tb/tb_lab8_sysid_check_master.sv
// Scoreboard bench: dut0 (latency 0, programmable stalls) and dut1 (latency 2).
module tb_lab8_sysid_check_master;

  localparam logic [31:0] TS_OK = 32'd1520803331;

  typedef struct packed {
    logic        pass;
    logic [1:0]  err;
    logic [31:0] id;
    logic [31:0] ts;
  } res_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic start1 = 1'b0;
  always #5 clock = ~clock;

  logic        a0_addr, a0_read, a0_wait, busy0, done0, pass0;
  logic [31:0] a0_data, id0, ts0;
  logic [1:0]  err0, rc0;
  logic        a1_addr, a1_read, a1_wait, busy1, done1, pass1;
  logic [31:0] a1_data, id1, ts1;
  logic [1:0]  err1, rc1;

  int   n_checks = 0;
  int   n_fail = 0;
  res_t q0[$];
  res_t q1[$];
  res_t e0, e1;

  logic [31:0] id_word = 32'd0;
  logic [31:0] ts_word = TS_OK;
  int wait_id = 0;
  int wait_ts = 0;
  int s0_wcnt = 0;
  int rd_cycles = 0;
  int ts_reads = 0;
  int base = 0;
  int tsb = 0;
  logic [1:0] s1_v = 2'b00;
  logic [1:0] s1_a = 2'b00;
  logic pd0 = 1'b0;
  logic pd1 = 1'b0;

  lab8_sysid_check_master dut0 (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(a0_addr), .avm_read(a0_read),
    .avm_readdata(a0_data), .avm_waitrequest(a0_wait),
    .busy(busy0), .done(done0), .pass(pass0), .err_code(err0),
    .id_value(id0), .ts_value(ts0), .retry_count(rc0)
  );

  lab8_sysid_check_master #(.READ_LATENCY(2)) dut1 (
    .clock(clock), .reset(reset), .start(start1),
    .avm_address(a1_addr), .avm_read(a1_read),
    .avm_readdata(a1_data), .avm_waitrequest(a1_wait),
    .busy(busy1), .done(done1), .pass(pass1), .err_code(err1),
    .id_value(id1), .ts_value(ts1), .retry_count(rc1)
  );

  // Slave model for dut0: zero latency, per-address stall count
  assign a0_wait = a0_read && (s0_wcnt < (a0_addr ? wait_ts : wait_id));
  assign a0_data = a0_addr ? ts_word : id_word;
  always @(posedge clock) begin
    s0_wcnt <= (a0_read && a0_wait) ? s0_wcnt + 1 : 0;
    if (a0_read) rd_cycles <= rd_cycles + 1;
    if (a0_read && a0_addr) ts_reads <= ts_reads + 1;
  end

  // Slave model for dut1: data valid only two cycles after the accept
  assign a1_wait = 1'b0;
  assign a1_data = s1_v[1] ? (s1_a[1] ? TS_OK : 32'd0) : 32'hDEADBEEF;
  always @(posedge clock) begin
    s1_v <= {s1_v[0], a1_read & ~a1_wait};
    s1_a <= {s1_a[0], a1_addr};
  end

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop an expected result whenever a DUT raises done
  always @(negedge clock) begin
    if (done0 && !pd0) begin
      check("dut0_result_expected", 72'(q0.size() != 0), 72'd1);
      if (q0.size() != 0) begin
        e0 = q0.pop_front();
        check("dut0_result", 72'({pass0, err0, id0, ts0}), 72'(e0));
        check("dut0_retry_count", 72'(rc0), 72'd0);
      end
    end
    if (done1 && !pd1) begin
      check("dut1_result_expected", 72'(q1.size() != 0), 72'd1);
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        check("dut1_result", 72'({pass1, err1, id1, ts1}), 72'(e1));
      end
    end
    pd0 = done0;
    pd1 = done1;
  end

  task automatic pulse_start();
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
  endtask

  task automatic wait_done0(input int max_cyc, input string name);
    int n = 0;
    while (!done0 && n < max_cyc) begin
      @(negedge clock);
      n++;
    end
    check({name, "_done0_seen"}, 72'(done0), 72'd1);
  endtask

  task automatic wait_done1(input int max_cyc, input string name);
    int n = 0;
    while (!done1 && n < max_cyc) begin
      @(negedge clock);
      n++;
    end
    check({name, "_done1_seen"}, 72'(done1), 72'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clock);
    check("reset_state0", 72'({busy0, done0, pass0, err0, id0, ts0, rc0, a0_read, a0_addr}), 72'd0);
    check("reset_state1", 72'({busy1, done1, pass1, err1, id1, ts1, rc1, a1_read, a1_addr}), 72'd0);

    // Auto-start after reset: both DUTs pass
    q0.push_back(res_t'({1'b1, 2'b00, 32'd0, TS_OK}));
    q1.push_back(res_t'({1'b1, 2'b00, 32'd0, TS_OK}));
    base = rd_cycles;
    reset = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    check("auto_done_by_cycle5", 72'({done0, pass0, err0}), 72'b1100);
    check("auto_read_cycles", 72'(rd_cycles - base), 72'd2);
    wait_done1(20, "lat2");

    // ID mismatch: TS read skipped, ts_value stays 0
    id_word = 32'd1;
    q0.push_back(res_t'({1'b0, 2'b01, 32'd1, 32'd0}));
    tsb = ts_reads;
    pulse_start();
    check("start_clears_done", 72'(done0), 72'd0);
    wait_done0(20, "id_mismatch");
    check("id_mismatch_no_ts_read", 72'(ts_reads - tsb), 72'd0);

    // TS mismatch
    id_word = 32'd0;
    ts_word = TS_OK - 32'd1;
    q0.push_back(res_t'({1'b0, 2'b10, 32'd0, TS_OK - 32'd1}));
    pulse_start();
    wait_done0(20, "ts_mismatch");

    // Timeout: 255 stall cycles on the ID read
    ts_word = TS_OK;
    wait_id = 255;
    q0.push_back(res_t'({1'b0, 2'b11, 32'd0, 32'd0}));
    base = rd_cycles;
    tsb = ts_reads;
    pulse_start();
    wait_done0(400, "timeout");
    check("timeout_read_cycles", 72'(rd_cycles - base), 72'd255);
    check("timeout_no_ts_read", 72'(ts_reads - tsb), 72'd0);

    // One stall short of the timeout still passes
    wait_id = 254;
    q0.push_back(res_t'({1'b1, 2'b00, 32'd0, TS_OK}));
    base = rd_cycles;
    pulse_start();
    wait_done0(400, "near_timeout");
    check("near_timeout_read_cycles", 72'(rd_cycles - base), 72'd256);

    // Start while busy is ignored, then reset mid TS read
    wait_id = 0;
    wait_ts = 20;
    pulse_start();
    n = 0;
    while (!(a0_read && a0_addr) && n < 10) begin
      @(negedge clock);
      n++;
    end
    check("ts_read_reached", 72'({a0_read, a0_addr}), 72'b11);
    pulse_start();
    check("busy_start_ignored", 72'({a0_read, a0_addr, busy0, done0}), 72'b1110);
    reset = 1'b1;
    @(negedge clock);
    check("reset_mid_read", 72'({busy0, done0, pass0, err0, id0, ts0, rc0, a0_read, a0_addr}), 72'd0);
    wait_ts = 0;
    q0.push_back(res_t'({1'b1, 2'b00, 32'd0, TS_OK}));
    q1.push_back(res_t'({1'b1, 2'b00, 32'd0, TS_OK}));
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    wait_done0(20, "after_reset");
    wait_done1(20, "after_reset");
    @(negedge clock);
    check("q0_drained", 72'(q0.size()), 72'd0);
    check("q1_drained", 72'(q1.size()), 72'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
